updown_cnt_sched: RTL and testbench
===================================

// Module: updown_cnt_sched
// PURPOSE
//  Shared-resource scheduler for the up/down counter datapath. Arbitrates NREQ requesters round-robin.
//  Each granted requester owns the counter for one burst: a clear, a set, or LEN up/down steps.
//  Sits between the control agents and the counter register; the register is internal, cnt is exported.
// PARAMETERS
//  WIDTH  4  counter width in bits
//  NREQ   2  number of requesters (>=2)
//  LW     4  burst-length field width; LEN range 0..2**LW-1
// PORTS
//  c      in   1          clock, rising edge
//  r      in   1          reset, synchronous, active-low
//  req    in   NREQ       request per requester; level, held until gnt
//  cmd    in   2*NREQ     per-requester command, slice i = cmd[2i+1:2i]
//  len    in   LW*NREQ    per-requester step count, slice i = len[LW*i+LW-1:LW*i]
//  gnt    out  NREQ       one-hot grant, 1-cycle pulse
//  owner  out  $clog2(NREQ)  index of current/last granted requester
//  busy   out  1          high from the cycle after gnt through the DONE cycle
//  done   out  1          1-cycle pulse at burst end
//  wrap   out  1          1-cycle pulse on boundary crossing/hit
//  cnt    out  WIDTH      counter value
// BEHAVIOUR
//  Reset, when r==0 at a rising edge of c: cnt=0, gnt=0, busy=0, done=0, wrap=0, owner=0.
//  Reset also sets the rr pointer to 0 and the state to IDLE. Reset wins over every other event, including mid-burst.
//  cmd encoding: 00 CLR (cnt<=0), 01 UP (+1), 10 DOWN (-1), 11 SET (cnt<=all ones).
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: if |req, pick the first requester with req set, searching from ptr upward with wrap-around.
//         Pulse gnt[win] for one cycle. Capture cmd/len of win and load owner. Go to RUN.
//         If req==0, stay in IDLE with no output change.
//   RUN:  CLR/SET: apply once, ignore len. Then go to DONE.
//         UP/DOWN with len==0: no step, go to DONE.
//         UP/DOWN with len>0: one step per cycle, len cycles total; go to DONE after the last step.
//   DONE: done=1 for one cycle, ptr<=owner+1 (mod NREQ), go to IDLE.
//         Earliest next gnt is the following cycle.
//  Latency: req seen in IDLE at edge k -> gnt high after edge k -> first step at edge k+1.
//  A step-mode burst finishes at edge k+len; done is high for the cycle after that.
//  Requests asserted during RUN/DONE are queued by level only; there is no buffering.
//  A requester that drops req before gnt simply loses the slot.
//  Wrap-around: UP from all-ones gives 0; DOWN from 0 gives all-ones. wrap pulses in the cycle after that step.
//  CLR/SET never assert wrap. gnt and done are never high in the same cycle.
//  owner holds its value after DONE until the next grant.
// CONFIGURATION
//  CNT_SATURATE_EN defined: UP at all-ones and DOWN at 0 leave cnt unchanged.
//   wrap pulses for each such blocked step; the burst still consumes len cycles.
//  Not defined: modulo-2**WIDTH wrap as above.
// STRUCTURE
//  Package updown_cnt_pkg holds:
//   typedef enum logic[1:0] {CMD_CLR, CMD_UP, CMD_DOWN, CMD_SET} cnt_cmd_t
//   typedef enum {S_IDLE, S_RUN, S_DONE} sched_state_t
//  Sub-module rr_arbiter (NREQ): inputs req and ptr; outputs one-hot win and its index. Purely combinational.
//  Counter register, len down-counter and FSM live in the top module.
// TESTING
//  1. Reset: drive r=0 for 2 cycles with random req -> all outputs 0, no gnt while r==0.
//  2. req0 UP len=3 from cnt=0 -> gnt=01 one cycle; cnt 1,2,3 on successive edges; done one cycle later; busy spans 4 cycles.
//  3. req0 and req1 both held, both UP len=1 -> grant order 0,1,0,1; owner alternates; no requester is granted twice in a row.
//  4. req1 DOWN len=2 at cnt=0 -> cnt 15 then 14, wrap pulses once.
//     With CNT_SATURATE_EN: cnt stays 0, wrap pulses twice.
//  5. SET then CLR with len=9 -> cnt=15, then cnt=0; each burst takes a single step, len is ignored, wrap stays 0.
//  6. Drop r mid-burst (cnt=5, 2 steps left) -> next edge cnt=0, busy=0, done is never pulsed; after release, req0 is granted first.

Source files
------------

// File: rtl/updown_cnt_sched_pkg.sv
// Shared types for the up/down counter scheduler.
// Command encoding, FSM state type and a small command classification helper.
package updown_cnt_pkg;

   typedef enum logic [1:0] {
      CMD_CLR  = 2'b00,
      CMD_UP   = 2'b01,
      CMD_DOWN = 2'b10,
      CMD_SET  = 2'b11
   } cnt_cmd_t;

   typedef enum {S_IDLE, S_RUN, S_DONE} sched_state_t;

   // UP/DOWN bursts walk len steps; CLR/SET complete in one shot.
   function automatic logic is_step_cmd(input cnt_cmd_t c);
      return (c == CMD_UP) || (c == CMD_DOWN);
   endfunction

endpackage

// File: rtl/updown_cnt_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or above ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [IW-1:0]   idx
);

   // Scan from ptr upward with wrap-around; first hit wins.
   always_comb begin
      logic found;
      int   cand;
      win   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int off = 0; off < NREQ; off++) begin
         cand = (int'(ptr) + off) % NREQ;
         if (!found && req[cand]) begin
            found     = 1'b1;
            win[cand] = 1'b1;
            idx       = IW'(cand);
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/updown_cnt_sched.sv
// Round-robin scheduled up/down counter. Each grant owns the counter for one
// burst (CLR, SET or len UP/DOWN steps).
// Build option: CNT_SATURATE_EN makes blocked UP/DOWN steps hold the counter
// at its limit instead of wrapping modulo 2**WIDTH.
module updown_cnt_sched
   import updown_cnt_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 2,
   parameter int LW    = 4
) (
   input  logic                      c,
   input  logic                      r,
   input  logic [NREQ-1:0]           req,
   input  logic [2*NREQ-1:0]         cmd,
   input  logic [LW*NREQ-1:0]        len,
   output logic [NREQ-1:0]           gnt,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      busy,
   output logic                      done,
   output logic                      wrap,
   output logic [WIDTH-1:0]          cnt
);

   localparam int OW = $clog2(NREQ);

   sched_state_t      state_r;
   logic [OW-1:0]     ptr_r;
   logic [OW-1:0]     owner_r;
   cnt_cmd_t          cmd_r;
   logic [LW-1:0]     len_r;
   logic [WIDTH-1:0]  cnt_r;
   logic [NREQ-1:0]   gnt_r;
   logic              busy_r;
   logic              done_r;
   logic              wrap_r;

   logic [NREQ-1:0]   win_s;
   logic [OW-1:0]     idx_s;
   logic [1:0]        cmd_sel_s;
   logic [LW-1:0]     len_sel_s;
   logic [WIDTH-1:0]  step_val_s;
   logic              step_wrap_s;
   logic [OW-1:0]     ptr_next_s;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (OW)
   ) u_arb (
      .req  (req),
      .ptr  (ptr_r),
      .win  (win_s),
      .idx  (idx_s)
   );

   // Pick the winner's command and length slices.
   always_comb begin
      cmd_sel_s = 2'b00;
      len_sel_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (idx_s == OW'(i)) begin
            cmd_sel_s = cmd[2*i +: 2];
            len_sel_s = len[LW*i +: LW];
         end else begin
            cmd_sel_s = cmd_sel_s;
         end
      end
   end

   // Next counter value for one UP/DOWN step and whether it hits a boundary.
   always_comb begin
      step_val_s  = cnt_r;
      step_wrap_s = 1'b0;
      case (cmd_r)
         CMD_UP: begin
            if (cnt_r == {WIDTH{1'b1}}) begin
               step_wrap_s = 1'b1;
`ifdef CNT_SATURATE_EN
               step_val_s  = cnt_r;
`else
               step_val_s  = '0;
`endif
            end else begin
               step_val_s  = cnt_r + WIDTH'(1);
            end
         end
         CMD_DOWN: begin
            if (cnt_r == '0) begin
               step_wrap_s = 1'b1;
`ifdef CNT_SATURATE_EN
               step_val_s  = cnt_r;
`else
               step_val_s  = {WIDTH{1'b1}};
`endif
            end else begin
               step_val_s  = cnt_r - WIDTH'(1);
            end
         end
         default: begin
            step_val_s  = cnt_r;
            step_wrap_s = 1'b0;
         end
      endcase
   end

   // Rotate the priority pointer past the requester that just finished.
   always_comb begin
      if (owner_r == OW'(NREQ - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = owner_r + OW'(1);
      end
   end

   // Scheduler FSM, counter register and remaining-step counter.
   always_ff @(posedge c) begin
      if (!r) begin
         state_r <= S_IDLE;
         ptr_r   <= '0;
         owner_r <= '0;
         cmd_r   <= CMD_CLR;
         len_r   <= '0;
         cnt_r   <= '0;
         gnt_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         wrap_r  <= 1'b0;
      end else begin
         gnt_r  <= '0;
         done_r <= 1'b0;
         wrap_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (|req) begin
                  gnt_r   <= win_s;
                  owner_r <= idx_s;
                  cmd_r   <= cnt_cmd_t'(cmd_sel_s);
                  len_r   <= len_sel_s;
                  busy_r  <= 1'b1;
                  state_r <= S_RUN;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_RUN: begin
               if (!is_step_cmd(cmd_r)) begin
                  cnt_r   <= (cmd_r == CMD_SET) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                  done_r  <= 1'b1;
                  state_r <= S_DONE;
               end else if (len_r == '0) begin
                  done_r  <= 1'b1;
                  state_r <= S_DONE;
               end else begin
                  cnt_r  <= step_val_s;
                  wrap_r <= step_wrap_s;
                  len_r  <= len_r - LW'(1);
                  if (len_r == LW'(1)) begin
                     done_r  <= 1'b1;
                     state_r <= S_DONE;
                  end else begin
                     state_r <= S_RUN;
                  end
               end
            end
            S_DONE: begin
               ptr_r   <= ptr_next_s;
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt   = gnt_r;
   assign owner = owner_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign wrap  = wrap_r;
   assign cnt   = cnt_r;

endmodule

// File: tb/tb_updown_cnt_sched.sv
// Directed self-checking bench for updown_cnt_sched (WIDTH=4, NREQ=2, LW=4).
module tb_updown_cnt_sched;

   logic       c = 1'b0;
   logic       r = 1'b0;
   logic [1:0] req = 2'b00;
   logic [3:0] cmd = 4'b0000;
   logic [7:0] len = 8'h00;
   logic [1:0] gnt;
   logic [0:0] owner;
   logic       busy;
   logic       done;
   logic       wrap;
   logic [3:0] cnt;

   int nvec = 0;
   int nerr = 0;

   updown_cnt_sched #(.WIDTH(4), .NREQ(2), .LW(4)) dut (
      .c(c), .r(r), .req(req), .cmd(cmd), .len(len),
      .gnt(gnt), .owner(owner), .busy(busy), .done(done), .wrap(wrap), .cnt(cnt)
   );

   always #5 c = ~c;

   task automatic tick;
      @(posedge c);
      #1;
   endtask

   task automatic test_reset;
      r = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req = 2'($urandom_range(0, 3));
         cmd = 4'($urandom_range(0, 15));
         len = 8'($urandom_range(0, 255));
         tick();
         nvec++;
         if ({gnt, owner, busy, done, wrap, cnt} !== 10'b0) begin
            nerr++;
            $display("FAIL reset: gnt=%b owner=%b busy=%b done=%b wrap=%b cnt=%0d, required all 0",
                     gnt, owner, busy, done, wrap, cnt);
         end
      end
      req = 2'b00;
      r   = 1'b1;
      tick();
   endtask

   task automatic test_up_len3;
      logic [3:0] exp_cnt [4];
      int busy_cycles;
      exp_cnt = '{4'd0, 4'd1, 4'd2, 4'd3};
      busy_cycles = 0;
      req = 2'b01; cmd = 4'b0001; len = 8'h03;
      tick();
      nvec++;
      if (gnt !== 2'b01 || owner !== 1'b0) begin
         nerr++;
         $display("FAIL up_gnt: gnt=%b owner=%b, required 01/0", gnt, owner);
      end
      req = 2'b00;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         if (busy === 1'b1) busy_cycles++;
         nvec++;
         if (cnt !== exp_cnt[i] || done !== (i == 3) || wrap !== 1'b0) begin
            nerr++;
            $display("FAIL up_step%0d: cnt=%0d done=%b wrap=%b, required cnt=%0d done=%b wrap=0",
                     i, cnt, done, wrap, exp_cnt[i], (i == 3));
         end
      end
      tick();
      nvec++;
      if (done !== 1'b0 || busy !== 1'b0 || cnt !== 4'd3) begin
         nerr++;
         $display("FAIL up_end: done=%b busy=%b cnt=%0d, required 0/0/3", done, busy, cnt);
      end
      nvec++;
      if (busy_cycles != 4) begin
         nerr++;
         $display("FAIL up_busy_span: got %0d cycles, required 4", busy_cycles);
      end
   endtask

   task automatic test_round_robin;
      logic [1:0] exp_gnt [4];
      int ng;
      int t;
      exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
      r = 1'b0; req = 2'b00; tick(); r = 1'b1;
      req = 2'b11; cmd = 4'b0101; len = 8'h11;
      ng = 0;
      t  = 0;
      while (ng < 4 && t < 40) begin
         tick();
         t++;
         nvec++;
         if (gnt !== 2'b00 && done === 1'b1) begin
            nerr++;
            $display("FAIL rr_gnt_done_overlap: gnt=%b done=%b", gnt, done);
         end
         if (gnt !== 2'b00) begin
            nvec++;
            if (gnt !== exp_gnt[ng] || owner !== ng[0]) begin
               nerr++;
               $display("FAIL rr_grant%0d: gnt=%b owner=%b, required %b/%0d",
                        ng, gnt, owner, exp_gnt[ng], ng % 2);
            end
            ng++;
         end
      end
      req = 2'b00;
      nvec++;
      if (ng != 4) begin
         nerr++;
         $display("FAIL rr_timeout: %0d grants seen, required 4", ng);
      end
      t = 0;
      while (done !== 1'b1 && t < 10) begin
         tick();
         t++;
      end
      tick();
      nvec++;
      if (cnt !== 4'd4) begin
         nerr++;
         $display("FAIL rr_cnt: cnt=%0d, required 4", cnt);
      end
   endtask

   task automatic test_wrap;
      logic [3:0] exp_c [2];
      logic       exp_w [2];
`ifdef CNT_SATURATE_EN
      exp_c = '{4'd0, 4'd0};
      exp_w = '{1'b1, 1'b1};
`else
      exp_c = '{4'd15, 4'd14};
      exp_w = '{1'b1, 1'b0};
`endif
      r = 1'b0; req = 2'b00; tick(); r = 1'b1;
      req = 2'b10; cmd = 4'b1000; len = 8'h20;
      tick();
      nvec++;
      if (gnt !== 2'b10 || owner !== 1'b1) begin
         nerr++;
         $display("FAIL wrap_gnt: gnt=%b owner=%b, required 10/1", gnt, owner);
      end
      req = 2'b00;
      for (int i = 0; i < 2; i++) begin
         tick();
         nvec++;
         if (cnt !== exp_c[i] || wrap !== exp_w[i] || done !== (i == 1)) begin
            nerr++;
            $display("FAIL wrap_step%0d: cnt=%0d wrap=%b done=%b, required cnt=%0d wrap=%b done=%b",
                     i, cnt, wrap, done, exp_c[i], exp_w[i], (i == 1));
         end
      end
      tick();
      nvec++;
      if (wrap !== 1'b0 || done !== 1'b0) begin
         nerr++;
         $display("FAIL wrap_end: wrap=%b done=%b, required 0/0", wrap, done);
      end
   endtask

   task automatic test_set_clr;
      logic [1:0] cmds [2];
      logic [3:0] exp_c [2];
      cmds  = '{2'b11, 2'b00};
      exp_c = '{4'd15, 4'd0};
      for (int b = 0; b < 2; b++) begin
         req = 2'b01; cmd = {2'b00, cmds[b]}; len = 8'h09;
         tick();
         nvec++;
         if (gnt !== 2'b01) begin
            nerr++;
            $display("FAIL setclr%0d_gnt: gnt=%b, required 01", b, gnt);
         end
         req = 2'b00;
         tick();
         nvec++;
         if (cnt !== exp_c[b] || done !== 1'b1 || wrap !== 1'b0) begin
            nerr++;
            $display("FAIL setclr%0d_apply: cnt=%0d done=%b wrap=%b, required cnt=%0d done=1 wrap=0",
                     b, cnt, done, wrap, exp_c[b]);
         end
         tick();
         nvec++;
         if (cnt !== exp_c[b] || done !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL setclr%0d_end: cnt=%0d done=%b busy=%b, required cnt=%0d 0 0",
                     b, cnt, done, busy, exp_c[b]);
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      int t;
      logic done_seen;
      r = 1'b0; req = 2'b00; tick(); r = 1'b1;
      req = 2'b01; cmd = 4'b0001; len = 8'h07;
      tick();
      req = 2'b00;
      for (int i = 0; i < 5; i++) tick();
      nvec++;
      if (cnt !== 4'd5 || busy !== 1'b1) begin
         nerr++;
         $display("FAIL mid_pre: cnt=%0d busy=%b, required 5/1", cnt, busy);
      end
      r = 1'b0;
      tick();
      nvec++;
      if (cnt !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || gnt !== 2'b00) begin
         nerr++;
         $display("FAIL mid_reset: cnt=%0d busy=%b done=%b gnt=%b, required 0", cnt, busy, done, gnt);
      end
      r = 1'b1;
      req = 2'b11; cmd = 4'b0101; len = 8'h11;
      tick();
      nvec++;
      if (gnt !== 2'b01 || owner !== 1'b0) begin
         nerr++;
         $display("FAIL mid_regrant: gnt=%b owner=%b, required 01/0", gnt, owner);
      end
      req = 2'b00;
      done_seen = 1'b0;
      t = 0;
      while (!done_seen && t < 10) begin
         tick();
         t++;
         if (done === 1'b1) done_seen = 1'b1;
      end
      nvec++;
      if (!done_seen || cnt !== 4'd1) begin
         nerr++;
         $display("FAIL mid_after: done_seen=%b cnt=%0d, required 1/1", done_seen, cnt);
      end
   endtask

   initial begin
      test_reset();
      test_up_len3();
      test_round_robin();
      test_wrap();
      test_set_clr();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
